// File: rtl/risc_pkg.sv
// Shared RISC pipeline definitions: datapath widths, ALU function codes and the
// decode-to-execute entry layout used by ex_issue.
package risc_pkg;

  localparam int XLEN   = 32;
  localparam int REG_AW = 5;

  typedef logic [REG_AW-1:0] reg_idx_t;
  typedef logic [XLEN-1:0]   xlen_t;

  localparam logic [3:0] ALU_ADD  = 4'h0;
  localparam logic [3:0] ALU_SUB  = 4'h8;
  localparam logic [3:0] ALU_SLL  = 4'h1;
  localparam logic [3:0] ALU_SLT  = 4'h2;
  localparam logic [3:0] ALU_SLTU = 4'h3;
  localparam logic [3:0] ALU_XOR  = 4'h4;
  localparam logic [3:0] ALU_SRL  = 4'h5;
  localparam logic [3:0] ALU_SRA  = 4'hD;
  localparam logic [3:0] ALU_OR   = 4'h6;
  localparam logic [3:0] ALU_AND  = 4'h7;

  // Resolved source values are kept rather than a/b so a stalled entry can refresh them.
  typedef struct packed {
    xlen_t      pc;
    reg_idx_t   rs1_idx;
    reg_idx_t   rs2_idx;
    xlen_t      rs1;
    xlen_t      rs2;
    xlen_t      imm;
    logic       a_sel_pc;
    logic       b_sel_imm;
    logic [3:0] funct;
    reg_idx_t   rd;
    logic       we;
  } issue_entry_t;

endpackage

// File: rtl/fwd_sel.sv
// Per-source operand bypass: picks MEM, then WB, then the register-file value.
// Bypassing exists only when EX_ISSUE_FWD_EN is defined; otherwise rf_val passes through.
module fwd_sel
  import risc_pkg::*;
(
  input  logic [REG_AW-1:0] idx,
  input  logic [XLEN-1:0]   rf_val,
  input  logic              mem_we,
  input  logic [REG_AW-1:0] mem_rd,
  input  logic [XLEN-1:0]   mem_val,
  input  logic              wb_we,
  input  logic [REG_AW-1:0] wb_rd,
  input  logic [XLEN-1:0]   wb_val,
  output logic [XLEN-1:0]   val
);

`ifdef EX_ISSUE_FWD_EN
  // x0 is hardwired, so a write targeting it must never be bypassed.
  always_comb begin
    val = rf_val;
    if (mem_we && (mem_rd == idx) && (idx != '0)) begin
      val = mem_val;
    end else if (wb_we && (wb_rd == idx) && (idx != '0)) begin
      val = wb_val;
    end
  end
`else
  logic unused_fwd;

  assign val        = rf_val;
  assign unused_fwd = ^{idx, mem_we, mem_rd, mem_val, wb_we, wb_rd, wb_val};
`endif

endmodule

// File: rtl/ex_issue.sv
// Decode-to-execute pipeline register feeding the ALU: one-entry skid-free stage
// with operand select and MEM/WB forwarding (enabled by EX_ISSUE_FWD_EN).
module ex_issue
  import risc_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [XLEN-1:0]   in_pc,
  input  logic [REG_AW-1:0] in_rs1_idx,
  input  logic [REG_AW-1:0] in_rs2_idx,
  input  logic [XLEN-1:0]   in_rs1_val,
  input  logic [XLEN-1:0]   in_rs2_val,
  input  logic [XLEN-1:0]   in_imm,
  input  logic              in_a_sel_pc,
  input  logic              in_b_sel_imm,
  input  logic [3:0]        in_funct,
  input  logic [REG_AW-1:0] in_rd,
  input  logic              in_we,
  input  logic              flush,
  input  logic              mem_we,
  input  logic [REG_AW-1:0] mem_rd,
  input  logic [XLEN-1:0]   mem_val,
  input  logic              wb_we,
  input  logic [REG_AW-1:0] wb_rd,
  input  logic [XLEN-1:0]   wb_val,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [XLEN-1:0]   alu_a,
  output logic [XLEN-1:0]   alu_b,
  output logic [3:0]        alu_funct,
  output logic [XLEN-1:0]   out_rs2_val,
  output logic [REG_AW-1:0] out_rd,
  output logic              out_we,
  output logic [XLEN-1:0]   out_pc
);

  logic         valid_q, valid_d;
  issue_entry_t entry_q, entry_d;
  logic [XLEN-1:0] rs1_fwd, rs2_fwd;
  logic         load;

  fwd_sel u_fwd_rs1 (
    .idx     (in_rs1_idx),
    .rf_val  (in_rs1_val),
    .mem_we  (mem_we),
    .mem_rd  (mem_rd),
    .mem_val (mem_val),
    .wb_we   (wb_we),
    .wb_rd   (wb_rd),
    .wb_val  (wb_val),
    .val     (rs1_fwd)
  );

  fwd_sel u_fwd_rs2 (
    .idx     (in_rs2_idx),
    .rf_val  (in_rs2_val),
    .mem_we  (mem_we),
    .mem_rd  (mem_rd),
    .mem_val (mem_val),
    .wb_we   (wb_we),
    .wb_rd   (wb_rd),
    .wb_val  (wb_val),
    .val     (rs2_fwd)
  );

  assign in_ready = !valid_q || out_ready;
  assign load     = in_valid && in_ready && !flush;

  // Flush beats load; a held entry picks up WB writes that retire during the stall.
  always_comb begin
    valid_d = valid_q;
    entry_d = entry_q;
    if (flush) begin
      valid_d = 1'b0;
    end else if (load) begin
      valid_d           = 1'b1;
      entry_d.pc        = in_pc;
      entry_d.rs1_idx   = in_rs1_idx;
      entry_d.rs2_idx   = in_rs2_idx;
      entry_d.rs1       = rs1_fwd;
      entry_d.rs2       = rs2_fwd;
      entry_d.imm       = in_imm;
      entry_d.a_sel_pc  = in_a_sel_pc;
      entry_d.b_sel_imm = in_b_sel_imm;
      entry_d.funct     = in_funct;
      entry_d.rd        = in_rd;
      entry_d.we        = in_we;
    end else if (valid_q && out_ready) begin
      valid_d = 1'b0;
`ifdef EX_ISSUE_FWD_EN
    end else if (valid_q && wb_we && (wb_rd != '0)) begin
      if (wb_rd == entry_q.rs1_idx) entry_d.rs1 = wb_val;
      if (wb_rd == entry_q.rs2_idx) entry_d.rs2 = wb_val;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      entry_q <= '0;
    end else begin
      valid_q <= valid_d;
      entry_q <= entry_d;
    end
  end

`ifndef EX_ISSUE_FWD_EN
  logic unused_idx;
  assign unused_idx = ^{entry_q.rs1_idx, entry_q.rs2_idx};
`endif

  assign out_valid   = valid_q;
  assign alu_a       = entry_q.a_sel_pc  ? entry_q.pc  : entry_q.rs1;
  assign alu_b       = entry_q.b_sel_imm ? entry_q.imm : entry_q.rs2;
  assign alu_funct   = entry_q.funct;
  assign out_rs2_val = entry_q.rs2;
  assign out_rd      = entry_q.rd;
  assign out_we      = valid_q && entry_q.we;
  assign out_pc      = entry_q.pc;

endmodule

// File: tb/tb_ex_issue.sv
// Directed scoreboard testbench for ex_issue; expectations follow EX_ISSUE_FWD_EN
// so the same bench covers both the forwarding and the plain build.
module tb_ex_issue;
   import risc_pkg::*;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_pc;
   logic [4:0]  in_rs1_idx;
   logic [4:0]  in_rs2_idx;
   logic [31:0] in_rs1_val;
   logic [31:0] in_rs2_val;
   logic [31:0] in_imm;
   logic        in_a_sel_pc;
   logic        in_b_sel_imm;
   logic [3:0]  in_funct;
   logic [4:0]  in_rd;
   logic        in_we;
   logic        flush;
   logic        mem_we;
   logic [4:0]  mem_rd;
   logic [31:0] mem_val;
   logic        wb_we;
   logic [4:0]  wb_rd;
   logic [31:0] wb_val;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] alu_a;
   logic [31:0] alu_b;
   logic [3:0]  alu_funct;
   logic [31:0] out_rs2_val;
   logic [4:0]  out_rd;
   logic        out_we;
   logic [31:0] out_pc;

   typedef struct {
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] rs2;
      logic [31:0] pc;
      logic [3:0]  funct;
      logic [4:0]  rd;
      logic        we;
   } expect_t;

   expect_t expQ[$];
   int total = 0;
   int bad   = 0;

   ex_issue dut (
      .clk          (clk),
      .rst          (rst),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .in_pc        (in_pc),
      .in_rs1_idx   (in_rs1_idx),
      .in_rs2_idx   (in_rs2_idx),
      .in_rs1_val   (in_rs1_val),
      .in_rs2_val   (in_rs2_val),
      .in_imm       (in_imm),
      .in_a_sel_pc  (in_a_sel_pc),
      .in_b_sel_imm (in_b_sel_imm),
      .in_funct     (in_funct),
      .in_rd        (in_rd),
      .in_we        (in_we),
      .flush        (flush),
      .mem_we       (mem_we),
      .mem_rd       (mem_rd),
      .mem_val      (mem_val),
      .wb_we        (wb_we),
      .wb_rd        (wb_rd),
      .wb_val       (wb_val),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .alu_a        (alu_a),
      .alu_b        (alu_b),
      .alu_funct    (alu_funct),
      .out_rs2_val  (out_rs2_val),
      .out_rd       (out_rd),
      .out_we       (out_we),
      .out_pc       (out_pc)
   );

   // Free-running 10-unit clock.
   always #5 clk = ~clk;

   // Hard stop in case the sequence ever wedges.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   // One comparison: counts it and reports any difference.
   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      total++;
      assert (observed === expected) else begin
         bad++;
         $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
      end
   endtask

   // Reference bypass: MEM over WB, never for x0, disabled in the plain build.
   function automatic logic [31:0] fwdModel(input logic [4:0] idx, input logic [31:0] rf);
`ifdef EX_ISSUE_FWD_EN
      if (mem_we && mem_rd == idx && idx != 5'd0) return mem_val;
      if (wb_we && wb_rd == idx && idx != 5'd0) return wb_val;
`endif
      return rf;
   endfunction

   // Advance to just after the next rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Drive one instruction; if it is expected to load, queue what it should look like downstream.
   task automatic applyStimulus(input logic expectLoad, input logic [31:0] pc,
                                input logic [4:0] rs1Idx, input logic [31:0] rs1Val,
                                input logic [4:0] rs2Idx, input logic [31:0] rs2Val,
                                input logic [31:0] imm, input logic aSel, input logic bSel,
                                input logic [3:0] funct, input logic [4:0] rd, input logic we);
      expect_t e;
      logic [31:0] r1, r2;
      in_valid     = 1'b1;
      in_pc        = pc;
      in_rs1_idx   = rs1Idx;
      in_rs1_val   = rs1Val;
      in_rs2_idx   = rs2Idx;
      in_rs2_val   = rs2Val;
      in_imm       = imm;
      in_a_sel_pc  = aSel;
      in_b_sel_imm = bSel;
      in_funct     = funct;
      in_rd        = rd;
      in_we        = we;
      if (expectLoad) begin
         r1      = fwdModel(rs1Idx, rs1Val);
         r2      = fwdModel(rs2Idx, rs2Val);
         e.a     = aSel ? pc : r1;
         e.b     = bSel ? imm : r2;
         e.rs2   = r2;
         e.pc    = pc;
         e.funct = funct;
         e.rd    = rd;
         e.we    = we;
         expQ.push_back(e);
      end
   endtask

   // Compare the presented entry with the oldest scoreboard entry without consuming it.
   task automatic checkFront(input string tag);
      expect_t e;
      checkOutput({tag, "_sb_nonempty"}, 32'(expQ.size() > 0), 32'd1);
      if (expQ.size() > 0) begin
         e = expQ[0];
         checkOutput({tag, "_valid"}, 32'(out_valid), 32'd1);
         checkOutput({tag, "_alu_a"}, alu_a, e.a);
         checkOutput({tag, "_alu_b"}, alu_b, e.b);
         checkOutput({tag, "_funct"}, 32'(alu_funct), 32'(e.funct));
         checkOutput({tag, "_rs2"}, out_rs2_val, e.rs2);
         checkOutput({tag, "_rd"}, 32'(out_rd), 32'(e.rd));
         checkOutput({tag, "_we"}, 32'(out_we), 32'(e.we));
         checkOutput({tag, "_pc"}, out_pc, e.pc);
      end
   endtask

   // Compare and retire the oldest entry (caller has out_ready high for the coming edge).
   task automatic popCheck(input string tag);
      checkFront(tag);
      if (expQ.size() > 0) void'(expQ.pop_front());
   endtask

   // Directed sequence: reset, basic transfer, back-pressure, forwarding, refresh, flush, selects, sweep.
   initial begin
      expect_t t;
      rst = 1'b1; in_valid = 1'b0; in_pc = '0; in_rs1_idx = '0; in_rs2_idx = '0;
      in_rs1_val = '0; in_rs2_val = '0; in_imm = '0; in_a_sel_pc = 1'b0; in_b_sel_imm = 1'b0;
      in_funct = '0; in_rd = '0; in_we = 1'b0; flush = 1'b0; mem_we = 1'b0; mem_rd = '0;
      mem_val = '0; wb_we = 1'b0; wb_rd = '0; wb_val = '0; out_ready = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      #1;
      checkOutput("rst_valid", 32'(out_valid), 32'd0);
      checkOutput("rst_in_ready", 32'(in_ready), 32'd1);
      checkOutput("rst_alu_a", alu_a, 32'd0);
      checkOutput("rst_alu_b", alu_b, 32'd0);
      checkOutput("rst_funct", 32'(alu_funct), 32'd0);
      checkOutput("rst_rs2", out_rs2_val, 32'd0);
      checkOutput("rst_rd", 32'(out_rd), 32'd0);
      checkOutput("rst_we", 32'(out_we), 32'd0);
      checkOutput("rst_pc", out_pc, 32'd0);

      // Basic ADD: 5 + 7, one-cycle latency, then drain.
      applyStimulus(1'b1, 32'h40, 5'd1, 32'd5, 5'd2, 32'd7, 32'd0, 1'b0, 1'b0, ALU_ADD, 5'd4, 1'b1);
      tick();
      in_valid = 1'b0;
      #1;
      popCheck("basic");
      tick();
      checkOutput("basic_drain", 32'(out_valid), 32'd0);

      // Back-pressure: hold A for three cycles while B waits, then release.
      out_ready = 1'b0;
      applyStimulus(1'b1, 32'h80, 5'd10, 32'h11, 5'd11, 32'h22, 32'd0, 1'b0, 1'b0, ALU_XOR, 5'd5, 1'b1);
      tick();
      applyStimulus(1'b1, 32'h84, 5'd12, 32'h33, 5'd13, 32'h44, 32'd0, 1'b0, 1'b0, ALU_OR, 5'd6, 1'b0);
      #1;
      for (int i = 0; i < 3; i++) begin
         checkOutput("bp_in_ready", 32'(in_ready), 32'd0);
         checkFront("bp_hold");
         tick();
      end
      out_ready = 1'b1;
      #1;
      checkOutput("bp_release_ready", 32'(in_ready), 32'd1);
      popCheck("bp_a");
      tick();
      in_valid = 1'b0;
      #1;
      popCheck("bp_b");
      tick();
      checkOutput("bp_no_dup", 32'(out_valid), 32'd0);

      // Forwarding: MEM beats WB, then WB alone, then x0 never bypassed.
      mem_we = 1'b1; mem_rd = 5'd3; mem_val = 32'h10;
      wb_we  = 1'b1; wb_rd  = 5'd3; wb_val  = 32'h20;
      applyStimulus(1'b1, 32'hC0, 5'd3, 32'd1, 5'd3, 32'd2, 32'd0, 1'b0, 1'b0, ALU_ADD, 5'd7, 1'b1);
      tick();
      popCheck("fwd_mem");
      mem_we = 1'b0;
      applyStimulus(1'b1, 32'hC4, 5'd3, 32'd1, 5'd3, 32'd2, 32'd0, 1'b0, 1'b0, ALU_ADD, 5'd7, 1'b1);
      tick();
      popCheck("fwd_wb");
      mem_we = 1'b1; mem_rd = 5'd0; wb_rd = 5'd0;
      applyStimulus(1'b1, 32'hC8, 5'd0, 32'h77, 5'd0, 32'h66, 32'd0, 1'b0, 1'b0, ALU_ADD, 5'd7, 1'b1);
      tick();
      popCheck("fwd_x0");
      in_valid = 1'b0; mem_we = 1'b0; wb_we = 1'b0;
      tick();

      // Stall refresh: WB to the held rs2 lands; a MEM write to rs1 is ignored while holding.
      out_ready = 1'b0;
      applyStimulus(1'b1, 32'h100, 5'd8, 32'h1, 5'd9, 32'h5, 32'd0, 1'b0, 1'b0, ALU_ADD, 5'd2, 1'b1);
      tick();
      in_valid = 1'b0;
      wb_we = 1'b1; wb_rd = 5'd9; wb_val = 32'hABCD;
      mem_we = 1'b1; mem_rd = 5'd8; mem_val = 32'hDEAD;
      tick();
      wb_we = 1'b0; mem_we = 1'b0;
`ifdef EX_ISSUE_FWD_EN
      t = expQ[0];
      t.b = 32'hABCD;
      t.rs2 = 32'hABCD;
      expQ[0] = t;
`endif
      #1;
      checkFront("refresh_hold");
      out_ready = 1'b1;
      #1;
      popCheck("refresh");
      tick();

      // Flush collides with an accepted instruction, then flush of a held entry.
      flush = 1'b1;
      applyStimulus(1'b0, 32'h200, 5'd1, 32'h9, 5'd2, 32'h9, 32'd0, 1'b0, 1'b0, ALU_AND, 5'd7, 1'b1);
      #1;
      checkOutput("flush_in_ready", 32'(in_ready), 32'd1);
      tick();
      flush = 1'b0; in_valid = 1'b0;
      #1;
      checkOutput("flush_valid", 32'(out_valid), 32'd0);
      checkOutput("flush_we", 32'(out_we), 32'd0);
      out_ready = 1'b0;
      applyStimulus(1'b1, 32'h204, 5'd1, 32'h9, 5'd2, 32'h9, 32'd0, 1'b0, 1'b0, ALU_AND, 5'd7, 1'b1);
      tick();
      in_valid = 1'b0; flush = 1'b1;
      tick();
      flush = 1'b0;
      void'(expQ.pop_front());
      #1;
      checkOutput("flush_held_valid", 32'(out_valid), 32'd0);
      checkOutput("flush_held_we", 32'(out_we), 32'd0);
      out_ready = 1'b1;

      // Operand selects: PC and immediate with SUB.
      applyStimulus(1'b1, 32'h100, 5'd4, 32'h99, 5'd5, 32'h55, 32'hFFFF_FFFC, 1'b1, 1'b1, ALU_SUB, 5'd1, 1'b1);
      tick();
      in_valid = 1'b0;
      popCheck("sel");
      tick();

      // Reset while stalled discards the held entry.
      out_ready = 1'b0;
      applyStimulus(1'b1, 32'h300, 5'd1, 32'h3, 5'd2, 32'h4, 32'd0, 1'b0, 1'b0, ALU_SLT, 5'd3, 1'b1);
      tick();
      in_valid = 1'b0; rst = 1'b1;
      tick();
      rst = 1'b0;
      void'(expQ.pop_front());
      #1;
      checkOutput("rst_stall_valid", 32'(out_valid), 32'd0);
      checkOutput("rst_stall_in_ready", 32'(in_ready), 32'd1);
      checkOutput("rst_stall_alu_a", alu_a, 32'd0);
      out_ready = 1'b1;

      // Back-to-back sweep of every function code with mixed selects.
      for (int i = 0; i < 16; i++) begin
         applyStimulus(1'b1, 32'h400 + 32'(i * 4), 5'd0, $urandom, 5'd0, $urandom, $urandom,
                       1'(i % 2), 1'((i / 2) % 2), 4'(i), 5'(i + 1), 1'((i / 4) % 2));
         tick();
         popCheck("sweep");
      end
      in_valid = 1'b0;
      tick();
      checkOutput("sweep_drain", 32'(out_valid), 32'd0);
      checkOutput("sb_empty", 32'(expQ.size()), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
